lisp_heap: RTL and testbench

LISP_HEAP -- requirements
Module: lisp_heap

---
 rtl/lisp_heap.sv | 204 ++++++++++++++++++++
 tb/tb_lisp_heap.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lisp_heap.sv
// Cons-cell heap: bump allocator over an internal word RAM with one read and one write port.
// Optional free list of released cells, enabled by defining LISP_HEAP_FREELIST_EN.
module lisp_heap #(
  parameter int                ADDR_W     = 12,
  parameter int                WORD_W     = 16,
  parameter int                MEM_DEPTH  = 256,
  parameter int                HEAP_START = 5,
  parameter logic [WORD_W-1:0] ERR_WORD   = WORD_W'(16'hAAAA)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [WORD_W-1:0] alloc_car,
  input  logic [WORD_W-1:0] alloc_cdr,
  output logic              alloc_done,
  output logic [ADDR_W-1:0] alloc_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              free_valid,
  output logic              free_ready,
  input  logic [ADDR_W-1:0] free_addr,
  output logic [ADDR_W-1:0] heap_ptr,
  output logic              oom
);

  localparam int              IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WR_CAR,
    WR_CDR,
    RD
`ifdef LISP_HEAP_FREELIST_EN
    , POP_RD,
    FREE_LINK
`endif
  } state_t;

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] target_q;
  logic [WORD_W-1:0] car_q, cdr_q;
  logic              fail_q, bump_q;
  logic              idle, free_pend, free_go, rd_go, alloc_go;
  logic              list_empty, exhausted, rd_in_range;
  logic [ADDR_W-1:0] raddr;
  logic [WORD_W-1:0] rd_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              unused_bits;

`ifdef LISP_HEAP_FREELIST_EN
  logic [ADDR_W-1:0] head_q, free_q;
  logic [WORD_W-1:0] pop_q;
  logic              free_ok;

  assign list_empty  = (head_q == '0);
  assign free_pend   = free_valid;
  assign free_ready  = idle;
  // Address 0 is NIL, and a cell must fit both words inside the RAM.
  assign free_ok     = (free_q != '0) && (({1'b0, free_q} + (ADDR_W+1)'(1)) < DEPTH_X);
  assign raddr       = rd_go ? rd_addr : head_q + ADDR_W'(1);
  assign unused_bits = ^{raddr, wr_addr, pop_q};
`else
  assign list_empty  = 1'b1;
  assign free_pend   = 1'b0;
  assign free_ready  = 1'b0;
  assign raddr       = rd_addr;
  assign unused_bits = ^{raddr, wr_addr, free_addr};
`endif

  assign idle        = rst_n && (state == IDLE);
  assign rd_ready    = idle && !free_pend;
  assign alloc_ready = rd_ready && !rd_valid;
  assign free_go     = free_valid && free_ready;
  assign rd_go       = rd_valid && rd_ready;
  assign alloc_go    = alloc_valid && alloc_ready;

  assign exhausted   = ({1'b0, heap_ptr} + (ADDR_W+1)'(1)) >= DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign rd_word     = mem[raddr[IDX_W-1:0]];

  assign alloc_done    = (state == WR_CDR);
  assign rd_data_valid = (state == RD);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (free_go) begin
`ifdef LISP_HEAP_FREELIST_EN
          state_nxt = FREE_LINK;
`endif
        end else if (rd_go) begin
          state_nxt = RD;
        end else if (alloc_go) begin
          if (!list_empty) begin
`ifdef LISP_HEAP_FREELIST_EN
            state_nxt = POP_RD;
`endif
          end else if (exhausted) begin
            state_nxt = WR_CDR;
          end else begin
            state_nxt = WR_CAR;
          end
        end
      end
      WR_CAR: state_nxt = WR_CDR;
      WR_CDR: state_nxt = IDLE;
      RD:     state_nxt = IDLE;
`ifdef LISP_HEAP_FREELIST_EN
      POP_RD:    state_nxt = WR_CAR;
      FREE_LINK: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = target_q;
    wr_data = car_q;
    case (state)
      WR_CAR: wr_en = 1'b1;
      WR_CDR: begin
        wr_en   = !fail_q;
        wr_addr = target_q + ADDR_W'(1);
        wr_data = cdr_q;
      end
`ifdef LISP_HEAP_FREELIST_EN
      FREE_LINK: begin
        wr_en   = free_ok;
        wr_addr = free_q + ADDR_W'(1);
        wr_data = WORD_W'(head_q);
      end
`endif
      default: ;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      heap_ptr   <= ADDR_W'(HEAP_START);
      oom        <= 1'b0;
      alloc_addr <= '0;
      rd_data    <= '0;
      rd_err     <= 1'b0;
      target_q   <= '0;
      car_q      <= '0;
      cdr_q      <= '0;
      fail_q     <= 1'b0;
      bump_q     <= 1'b0;
`ifdef LISP_HEAP_FREELIST_EN
      head_q     <= '0;
      free_q     <= '0;
      pop_q      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (rd_go) begin
        rd_data <= rd_in_range ? rd_word : ERR_WORD;
        rd_err  <= !rd_in_range;
      end
      if (alloc_go) begin
        car_q  <= alloc_car;
        cdr_q  <= alloc_cdr;
        bump_q <= list_empty;
        fail_q <= list_empty && exhausted;
`ifdef LISP_HEAP_FREELIST_EN
        target_q <= list_empty ? heap_ptr : head_q;
        pop_q    <= rd_word;
`else
        target_q <= heap_ptr;
`endif
        if (list_empty && exhausted) begin
          alloc_addr <= '0;
          oom        <= 1'b1;
        end
      end
      if (state == WR_CAR) alloc_addr <= target_q;
      if (state == WR_CDR && bump_q && !fail_q) heap_ptr <= heap_ptr + ADDR_W'(2);
`ifdef LISP_HEAP_FREELIST_EN
      if (free_go) free_q <= free_addr;
      if (state == POP_RD) head_q <= ADDR_W'(pop_q);
      if (state == FREE_LINK && free_ok) head_q <= free_q;
`endif
    end
  end

endmodule

// File: tb/tb_lisp_heap.sv
// Directed bench for lisp_heap; covers the free-list scenario when LISP_HEAP_FREELIST_EN is defined.
module tb_lisp_heap;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_ready, alloc_done;
  logic [15:0] alloc_car, alloc_cdr;
  logic [11:0] alloc_addr;
  logic        rd_valid, rd_ready, rd_data_valid, rd_err;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic        free_valid, free_ready;
  logic [11:0] free_addr;
  logic [11:0] heap_ptr;
  logic        oom;

  int nvec = 0;
  int nerr = 0;

  lisp_heap dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_car(alloc_car), .alloc_cdr(alloc_cdr),
    .alloc_done(alloc_done), .alloc_addr(alloc_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
    .free_valid(free_valid), .free_ready(free_ready), .free_addr(free_addr),
    .heap_ptr(heap_ptr), .oom(oom)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_alloc(input logic [15:0] car, input logic [15:0] cdr,
                          output logic [11:0] addr, output int lat);
    @(negedge clk);
    alloc_valid = 1'b1; alloc_car = car; alloc_cdr = cdr;
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!alloc_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    addr = alloc_addr;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [15:0] exp_d, input logic exp_e,
                         input logic chk_d, input string tag);
    int lat;
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = a;
    @(posedge clk);
    #1 rd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rd_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, rd_err, exp_e);
    if (chk_d) chk({tag, "_data"}, rd_data, exp_d);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] addr;
    int lat;
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_car = '0; alloc_cdr = '0;
    rd_valid = 1'b0; rd_addr = '0;
    free_valid = 1'b0; free_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_heap_ptr", heap_ptr, 5);
    chk("rst_oom", oom, 0);
    chk("rst_alloc_ready", alloc_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_free_ready", free_ready, 0);
    chk("rst_alloc_done", alloc_done, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_alloc_addr", alloc_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_alloc_ready", alloc_ready, 1);

    do_alloc(16'h0007, 16'h0000, addr, lat);
    chk("a1_lat", lat, 2);
    chk("a1_addr", addr, 5);
    @(negedge clk);
    chk("a1_heap_ptr", heap_ptr, 7);
    chk("a1_done_pulse", alloc_done, 0);
    chk("a1_addr_hold", alloc_addr, 5);
    do_read(12'd5, 16'h0007, 1'b0, 1'b1, "r5");
    do_read(12'd6, 16'h0000, 1'b0, 1'b1, "r6");

    do_alloc(16'h1234, 16'h0005, addr, lat);
    chk("a2_lat", lat, 2);
    chk("a2_addr", addr, 7);
    @(negedge clk);
    chk("a2_heap_ptr", heap_ptr, 9);
    do_read(12'd7, 16'h1234, 1'b0, 1'b1, "r7");
    do_read(12'd8, 16'h0005, 1'b0, 1'b1, "r8");

    do_read(12'd300, 16'hAAAA, 1'b1, 1'b1, "r300");
    @(negedge clk);
    chk("r300_data_hold", rd_data, 16'hAAAA);
    chk("r300_heap_ptr", heap_ptr, 9);
    chk("r300_alloc_addr", alloc_addr, 7);
    do_read(12'd7, 16'h1234, 1'b0, 1'b1, "r7b");
    do_read(12'd255, 16'h0000, 1'b0, 1'b0, "r255");
    do_read(12'd256, 16'hAAAA, 1'b1, 1'b1, "r256");

`ifdef LISP_HEAP_FREELIST_EN
    @(negedge clk);
    free_valid = 1'b1; free_addr = 12'd5;
    rd_valid = 1'b1; rd_addr = 12'd7;
    alloc_valid = 1'b1; alloc_car = 16'h00AB; alloc_cdr = 16'h00CD;
    #1;
    chk("pri_free_ready", free_ready, 1);
    chk("pri_rd_ready0", rd_ready, 0);
    chk("pri_alloc_ready0", alloc_ready, 0);
    @(posedge clk);
    #1 free_valid = 1'b0;
    @(negedge clk);
    chk("pri_link_rd_ready", rd_ready, 0);
    @(negedge clk);
    chk("pri_rd_ready1", rd_ready, 1);
    chk("pri_alloc_ready1", alloc_ready, 0);
    @(posedge clk);
    #1 rd_valid = 1'b0;
    @(negedge clk);
    chk("pri_rd_valid", rd_data_valid, 1);
    chk("pri_rd_data", rd_data, 16'h1234);
    chk("pri_alloc_ready2", alloc_ready, 0);
    @(negedge clk);
    chk("pri_alloc_ready3", alloc_ready, 1);
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!alloc_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("pop_lat", lat, 3);
    chk("pop_addr", alloc_addr, 5);
    @(negedge clk);
    chk("pop_heap_ptr", heap_ptr, 9);
    do_read(12'd5, 16'h00AB, 1'b0, 1'b1, "pop_r5");
    do_read(12'd6, 16'h00CD, 1'b0, 1'b1, "pop_r6");
    do_alloc(16'h0001, 16'h0002, addr, lat);
    chk("post_pop_lat", lat, 2);
    chk("post_pop_addr", addr, 9);
    @(negedge clk);
    chk("post_pop_heap_ptr", heap_ptr, 11);
`else
    @(negedge clk);
    free_valid = 1'b1; free_addr = 12'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("nofl_free_ready", free_ready, 0);
      chk("nofl_heap_ptr", heap_ptr, 9);
    end
    chk("nofl_alloc_ready", alloc_ready, 1);
    free_valid = 1'b0;
`endif

    // Reset while the car word is being written.
    @(negedge clk);
    alloc_valid = 1'b1; alloc_car = 16'h5555; alloc_cdr = 16'h6666;
    @(posedge clk);
    #1 alloc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_done", alloc_done, 0);
    end
    chk("rst_mid_ready", alloc_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_done2", alloc_done, 0);
    chk("rst_mid_heap_ptr", heap_ptr, 5);
    chk("rst_mid_alloc_ready", alloc_ready, 1);

    // Fill the bump region: cells at 5, 7, ..., 253.
    for (int i = 0; i < 125; i++) begin
      do_alloc(16'(i), 16'(i + 256), addr, lat);
      chk("fill_addr", addr, 5 + 2 * i);
    end
    @(negedge clk);
    chk("fill_heap_ptr", heap_ptr, 255);
    chk("fill_oom", oom, 0);
    do_alloc(16'hBEEF, 16'hCAFE, addr, lat);
    chk("oom_lat", lat, 1);
    chk("oom_addr", addr, 0);
    @(negedge clk);
    chk("oom_flag", oom, 1);
    chk("oom_heap_ptr", heap_ptr, 255);
    repeat (5) @(negedge clk);
    chk("oom_sticky", oom, 1);
    do_alloc(16'hBEEF, 16'hCAFE, addr, lat);
    chk("oom2_addr", addr, 0);
    do_read(12'd253, 16'd124, 1'b0, 1'b1, "last_car");
    do_read(12'd254, 16'd380, 1'b0, 1'b1, "last_cdr");
    @(negedge clk);
    chk("end_oom", oom, 1);
    chk("end_heap_ptr", heap_ptr, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
